// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg : shared UART constants and state encodings (rx and tx)     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_CHK = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        BREAK     = 3'd4
    } rx_state_e;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_2ff : two-flop synchronizer for a single asynchronous input     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/uart_rx_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_fsm : 8N1 UART receiver, mid-bit sampling, framing detect    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int unsigned DIVISOR = 10
) (
    input  logic                 clk,
    input  logic                 RSTn,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam logic [31:0] HALF_DIV  = 32'(DIVISOR >> 1);
    localparam logic [31:0] BAUD_LAST = 32'(DIVISOR - 1);
    localparam logic [31:0] HALF_LAST = HALF_DIV - 32'd1;

    logic                 rx_s;
    rx_state_e            state_q,  state_d;
    logic [31:0]          baud_q,   baud_d;
    logic [3:0]           bit_q,    bit_d;
    logic [DATA_BITS-1:0] shift_q,  shift_d;
    logic [DATA_BITS-1:0] data_q,   data_d;
    logic                 valid_q,  valid_d;
    logic                 ferr_q,   ferr_d;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .rst_n (RSTn),
        .d_i   (RX),
        .q_o   (rx_s)
    );

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (!rx_s) begin
                    state_d = START_CHK;
                end
            end

            // A start bit that is gone by mid-bit is treated as line noise.
            START_CHK: begin
                if (baud_q == HALF_LAST) begin
                    baud_d  = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    baud_d = baud_q + 32'd1;
                end
            end

            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d                = '0;
                    shift_d[bit_q[2:0]]   = rx_s;
                    bit_d                 = bit_q + 4'd1;
                    if (bit_q == 4'(DATA_BITS - 1)) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_d = baud_q + 32'd1;
                end
            end

            STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    baud_d = baud_q + 32'd1;
                end
            end

            // Hold here until the line returns high so a stuck-low line cannot re-arm.
            BREAK: begin
                baud_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != IDLE);

endmodule : uart_rx_fsm
`default_nettype wire

// File: tb/tb_uart_rx_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_rx_fsm : randomized frames against a timing/event model      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_uart_rx_fsm;

    localparam int DIV   = 10;
    localparam int HALF  = DIV / 2;
    localparam int DIV2  = 11;
    localparam int HALF2 = DIV2 / 2;

    logic       clk  = 1'b0;
    logic       RSTn = 1'b0;
    logic       RX   = 1'b1;
    logic       RX2  = 1'b1;
    logic [7:0] data_out,  data_out2;
    logic       data_valid, data_valid2;
    logic       frame_err,  frame_err2;
    logic       busy,       busy2;

    uart_rx_fsm #(.DIVISOR(DIV)) u_dut (
        .clk        (clk),
        .RSTn       (RSTn),
        .RX         (RX),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    uart_rx_fsm #(.DIVISOR(DIV2)) u_dut_lb (
        .clk        (clk),
        .RSTn       (RSTn),
        .RX         (RX2),
        .data_out   (data_out2),
        .data_valid (data_valid2),
        .frame_err  (frame_err2),
        .busy       (busy2)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         id;
        longint     cyc;
        logic       v;
        logic       fe;
        logic [7:0] d;
        logic       b;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        obs_q[$];
    int         n_tests   = 0;
    int         n_fail    = 0;
    logic [7:0] last_good = 8'h00;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every strobe from either receiver is logged with its cycle and outputs.
    always @(negedge clk) begin
        if (RSTn && (data_valid || frame_err))
            obs_q.push_back('{0, cyc, data_valid, frame_err, data_out, busy});
        if (RSTn && (data_valid2 || frame_err2))
            obs_q.push_back('{1, cyc, data_valid2, frame_err2, data_out2, busy2});
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Line falls at cycle F; rx_s sees it at F+2; stop sample at F+2+HALF+9*DIV; strobe one cycle later.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int hold, input int gap);
        longint fall;
        ev_t    e;
        RX   = 1'b0;
        fall = cyc;
        step(DIV);
        for (int k = 0; k < 8; k++) begin
            RX = b[k];
            step(DIV);
        end
        RX = stop_ok;
        step(DIV);
        if (stop_ok) last_good = b;
        e.id  = 0;
        e.cyc = fall + 2 + HALF + 9 * DIV + 1;
        e.v   = stop_ok;
        e.fe  = !stop_ok;
        e.d   = last_good;
        e.b   = !stop_ok;
        exp_q.push_back(e);
        if (!stop_ok) begin
            step(hold);
            check("break_busy", busy, 1);
            RX = 1'b1;
            step(3);
            check("break_exit", busy, 0);
        end
        RX = 1'b1;
        step(gap);
    endtask

    task automatic glitch(input int len);
        RX = 1'b0;
        for (int i = 0; i < len + HALF + 4; i++) begin
            if (i == len) RX = 1'b1;
            if (i == 3) check("glitch_busy", busy, 1);
            step(1);
        end
        check("glitch_idle", busy, 0);
    endtask

    task automatic reset_mid_frame();
        RX = 1'b0;
        step(DIV * 4);
        RSTn = 1'b0;
        RX   = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_valid", data_valid, 0);
        check("midrst_ferr", frame_err, 0);
        check("midrst_data", data_out, 8'h00);
        last_good = 8'h00;
        step(3);
        RSTn = 1'b1;
        step(5);
    endtask

    task automatic send_lb(input logic [7:0] b);
        longint fall;
        ev_t    e;
        RX2  = 1'b0;
        fall = cyc;
        step(DIV2);
        for (int k = 0; k < 8; k++) begin
            RX2 = b[k];
            step(DIV2);
        end
        RX2 = 1'b1;
        step(DIV2 + 4);
        e.id  = 1;
        e.cyc = fall + 2 + HALF2 + 9 * DIV2 + 1;
        e.v   = 1'b1;
        e.fe  = 1'b0;
        e.d   = b;
        e.b   = 1'b0;
        exp_q.push_back(e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rb;
        logic       rok;
        int         nev;

        RSTn = 1'b0;
        step(3);
        check("rst_data", data_out, 8'h00);
        check("rst_valid", data_valid, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_busy", busy, 0);
        RSTn = 1'b1;
        step(5);

        send_frame(8'hA5, 1'b1, 0, 5);
        reset_mid_frame();
        send_frame(8'h81, 1'b1, 0, 5);
        glitch(3);
        send_frame(8'h3C, 1'b0, 30, 4);
        send_frame(8'h00, 1'b1, 0, 0);
        send_frame(8'hFF, 1'b1, 0, 6);

        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 3) == 0) glitch(int'($urandom_range(1, HALF - 1)));
            rb  = 8'($urandom);
            rok = ($urandom_range(0, 3) != 0);
            send_frame(rb, rok, int'($urandom_range(1, 25)),
                       ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 12)));
        end

        send_lb(8'h5A);
        send_lb(8'hC3);
        for (int i = 0; i < 3; i++) send_lb(8'($urandom));

        step(30);
        check("event_count", obs_q.size(), exp_q.size());
        nev = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < nev; i++) begin
            check($sformatf("ev%0d_id", i),    obs_q[i].id,  exp_q[i].id);
            check($sformatf("ev%0d_cyc", i),   obs_q[i].cyc, exp_q[i].cyc);
            check($sformatf("ev%0d_valid", i), obs_q[i].v,   exp_q[i].v);
            check($sformatf("ev%0d_ferr", i),  obs_q[i].fe,  exp_q[i].fe);
            check($sformatf("ev%0d_data", i),  obs_q[i].d,   exp_q[i].d);
            check($sformatf("ev%0d_busy", i),  obs_q[i].b,   exp_q[i].b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_uart_rx_fsm
`default_nettype wire

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
UART receive stage; the downstream counterpart of tx_fsm. It consumes the serial line, hunts for a start bit and samples each bit at mid-period. It returns one 8N1 byte (LSB first) with a 1-cycle valid strobe, plus a framing-error strobe. It sits between the external RX pin and the byte consumer (FIFO/register file), on the same clock as tx_fsm.

Parameters:
divisor, 10, clock cycles per bit period on the line; must be >= 4; half_div = divisor >> 1

Ports:
clk  input  1  system clock, all logic on posedge
RSTn  input  1  asynchronous, active-low reset
RX  input  1  asynchronous serial line, idle high
data_out  output  8  last correctly framed byte; held until next good frame
data_valid  output  1  1-cycle pulse: data_out updated this cycle
frame_err  output  1  1-cycle pulse: stop bit sampled low
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, RSTn=0): state=IDLE, sync flops=1, baud_count=0, bit_count=0, shift reg=0, data_out=8'h00, data_valid=0, frame_err=0, busy=0. Reset mid-frame aborts immediately; no strobe is issued.
- RX passes through a 2-flop synchronizer (reset value 1) -> rx_s. All decisions use rx_s only.
- State IDLE: baud_count=0, bit_count=0. If rx_s==0 -> START_CHK.
- State START_CHK: baud_count increments from 0. At baud_count==half_div-1, sample rx_s: 0 -> DATA with baud_count=0; 1 -> IDLE (glitch reject, no strobe).
- State DATA: baud_count increments from 0. At baud_count==divisor-1, sample rx_s into shift[bit_count], set baud_count=0, bit_count+1. After bit_count 7 is sampled -> STOP.
- State STOP: at baud_count==divisor-1, sample rx_s.
  - rx_s=1: data_out<=shift, data_valid=1 for the next cycle, -> IDLE.
  - rx_s=0: frame_err=1 for the next cycle, data_out unchanged, -> BREAK.
- State BREAK: wait until rx_s==1, then -> IDLE. This prevents a held-low line from re-triggering a frame.
- Timing: let t0 be the first cycle rx_s==0 in IDLE (t0 = RX pin falling edge + 2 clocks).
  - Start check at t0+half_div.
  - Data bit k sampled at t0+half_div+(k+1)*divisor, for k=0..7.
  - Stop sampled at t0+half_div+9*divisor.
  - data_valid/frame_err high exactly in cycle t0+half_div+9*divisor+1.
- Back-to-back: IDLE is re-entered right after the stop sample, so a new start edge arriving half a bit later is caught.
- data_valid and frame_err are never high together; both are registered outputs.
- Widths: baud_count 32-bit, compared against divisor-1 and half_div-1 (32-bit). bit_count 4-bit, no wrap beyond 8.

Decomposition:
- Shared package uart_pkg:
  - rx state enum (IDLE, START_CHK, DATA, STOP, BREAK), 3-bit
  - DATA_BITS=8
  - tx state constants moved here for symmetry
- One sub-module sync_2ff (1-bit, reset value parameter = 1) for the RX synchronizer. It is reusable for other async inputs.

Test Plan:
1. Reset with RX=1 -> data_out=0x00, data_valid=0, frame_err=0, busy=0. Assert RSTn=0 after 3 data bits of a frame, release, send 0x81 -> single valid, data_out=0x81.
2. divisor=10, ideal frame 0xA5, stop=1 -> data_valid high only at t0+96, data_out=0xA5, busy low from t0+96.
3. RX low for 3 cycles then high (divisor=10) -> busy pulses during START_CHK, returns IDLE, no data_valid, no frame_err.
4. Frame 0x3C with stop=0, then RX held low 30 cycles -> frame_err pulse at t0+96, data_out stays 0xA5, busy until rx_s=1, no new frame triggered.
5. Back-to-back 0x00 then 0xFF, stop bit exactly divisor cycles -> two data_valid pulses, data_out 0x00 then 0xFF.
6. Loopback: tx_fsm (divisor=10, bit period 11 clocks) drives RX of uart_rx_fsm (divisor=11), send 0x5A then 0xC3 -> data_out 0x5A then 0xC3, no frame_err.
